// File: rtl/rng_range_pkg.sv
// Shared widths, FSM state type and the restoring-division step for rng_range.
package rng_pkg;
  localparam int RNG_W   = 32;
  localparam int BOUND_W = 16;

  typedef enum logic [1:0] {IDLE, THRESH, DRAW, DONE} rr_state_t;
  typedef logic [BOUND_W-1:0] thr_t;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  // r < d on entry, so the partial remainder never exceeds 2d-1 and the
  // result always fits back into 16 bits.
  function automatic logic [15:0] rem_step(input logic [15:0] r,
                                           input logic        b,
                                           input logic [15:0] d);
    logic [16:0] t;
    t = {r, b};
    if (t >= {1'b0, d}) t = t - {1'b0, d};
    return t[15:0];
  endfunction
endpackage

// File: rtl/rng_range_if.sv
// Request/response handshake between a bound requester and rng_range.
interface rng_range_if;
  import rng_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [BOUND_W-1:0] req_bound;
  logic               resp_valid;
  logic               resp_ready;
  logic [BOUND_W-1:0] resp_value;

  modport master (output req_valid, req_bound, resp_ready,
                  input  req_ready, resp_valid, resp_value);
  modport slave  (input  req_valid, req_bound, resp_ready,
                  output req_ready, resp_valid, resp_value);
endinterface

// File: rtl/rng_range_rem_iter.sv
// Iterative restoring remainder: 32-bit dividend mod 16-bit divisor.
// The first quotient bit is resolved on the start edge, so the remainder is
// final 32 cycles after start and done pulses in that cycle.
module rem_iter
  import rng_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] rem
);
  logic [31:0] dvd_q;
  logic [15:0] dsr_q;
  logic [15:0] rem_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // Load and take step 1 on start, then one step per cycle until step 32.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        rem_q  <= rem_step(16'd0, dividend[31], divisor);
        dvd_q  <= {dividend[30:0], 1'b0};
        dsr_q  <= divisor;
        cnt_q  <= 5'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_step(rem_q, dvd_q[31], dsr_q);
        dvd_q <= {dvd_q[30:0], 1'b0};
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign rem  = rem_q;
endmodule

// File: rtl/rng_range.sv
// Unbiased bounded integers from the PRNG stream (Lemire multiply-and-reject).
// The rejection threshold (2^32 mod N) is computed once per bound and cached.
module rng_range
  import rng_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [RNG_W-1:0] rng,
  rng_range_if.slave       bus,
  output logic [15:0]      reject_cnt
);
  rr_state_t                state_q;
  logic [BOUND_W-1:0]       n_q;
  logic [BOUND_W-1:0]       cached_n_q;
  logic [BOUND_W-1:0]       resp_value_q;
  thr_t                     thr_q;
  logic                     cache_vld_q;
  logic                     req_ready_q;
  logic                     resp_valid_q;
  logic [15:0]              rej_q;

  logic                     req_fire_d;
  logic                     hit_d;
  logic                     div_start_d;
  logic [RNG_W-1:0]         dividend_d;
  logic                     div_busy;
  logic                     div_done;
  logic [15:0]              div_rem;
  logic [RNG_W+BOUND_W-1:0] m_d;
  logic                     accept_d;
  logic [BOUND_W-1:0]       value_d;

  // N==0 needs no threshold; otherwise a matching cached bound skips THRESH.
  assign req_fire_d  = (state_q == IDLE) && bus.req_valid && !div_busy;
  assign hit_d       = (bus.req_bound == '0) ||
                       (cache_vld_q && (bus.req_bound == cached_n_q));
  assign div_start_d = req_fire_d && !hit_d;
  // 2^32 - N, expressed in 32 bits; its remainder mod N equals 2^32 mod N.
  assign dividend_d  = ~{{(RNG_W-BOUND_W){1'b0}}, bus.req_bound} + 32'd1;

  rem_iter u_rem (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_d),
    .dividend (dividend_d),
    .divisor  (bus.req_bound),
    .busy     (div_busy),
    .done     (div_done),
    .rem      (div_rem)
  );

  // Single-cycle 32x16 product; low word vs threshold decides acceptance.
  assign m_d      = {{BOUND_W{1'b0}}, rng} * {{RNG_W{1'b0}}, n_q};
  assign accept_d = (n_q == '0) ||
                    (m_d[RNG_W-1:0] >= {{(RNG_W-BOUND_W){1'b0}}, thr_q});
  assign value_d  = (n_q == '0) ? rng[BOUND_W-1:0]
                                : m_d[RNG_W+BOUND_W-1:RNG_W];

  // Control FSM with registered handshake outputs, cache and reject counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      cached_n_q   <= '0;
      thr_q        <= '0;
      cache_vld_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_value_q <= '0;
      rej_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_fire_d) begin
          n_q         <= bus.req_bound;
          req_ready_q <= 1'b0;
          state_q     <= hit_d ? DRAW : THRESH;
        end
        THRESH: if (div_done) begin
          thr_q       <= div_rem;
          cached_n_q  <= n_q;
          cache_vld_q <= 1'b1;
          state_q     <= DRAW;
        end
        DRAW: begin
          if (accept_d) begin
            resp_value_q <= value_d;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (rej_q != 16'hFFFF) begin
            rej_q <= rej_q + 16'd1;
          end
        end
        DONE: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_value = resp_value_q;
  assign reject_cnt     = rej_q;
endmodule

// File: tb/tb_rng_range.sv
// Directed bench for rng_range: a reference model predicts value, latency and
// reject count for each request into a scoreboard queue checked on response.
module tb_rng_range;
  import rng_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [RNG_W-1:0] rng;
  logic [15:0]      reject_cnt;

  rng_range_if bus();

  rng_range dut (
    .clk        (clk),
    .reset      (reset),
    .rng        (rng),
    .bus        (bus.slave),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          lat;
    logic [15:0] rej;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_cv     = 1'b0;
  logic [15:0] m_cn     = 16'd0;
  logic [15:0] m_rej    = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: cycle 0 is the accept cycle, first draw at 1 (hit/N==0) or 33.
  task automatic predict(input logic [15:0] n, input logic [31:0] r0,
                         input logic [31:0] r1, input int sw);
    exp_t        e;
    logic [63:0] thr, m;
    logic [31:0] r;
    int          c;
    bit          acc;
    c   = (n == 16'd0 || (m_cv && m_cn == n)) ? 1 : 33;
    thr = 64'd0;
    if (n != 16'd0) begin
      m_cv = 1'b1;
      m_cn = n;
      thr  = 64'h1_0000_0000 % {48'd0, n};
    end
    acc   = 1'b0;
    e.val = 16'd0;
    for (int k = 0; k < 64 && !acc; k++) begin
      r = (c >= sw) ? r1 : r0;
      m = {32'd0, r} * {48'd0, n};
      if (n == 16'd0) begin
        e.val = r[15:0]; acc = 1'b1;
      end else if (m[31:0] >= thr[31:0]) begin
        e.val = m[47:32]; acc = 1'b1;
      end else begin
        if (m_rej != 16'hFFFF) m_rej++;
        c++;
      end
    end
    e.lat = c + 1;
    e.rej = m_rej;
    sb.push_back(e);
  endtask

  // Issue one request; rng is r0 before cycle sw and r1 from then on.
  // The response is held back for 'hold' extra cycles before being taken.
  task automatic run_req(input logic [15:0] n, input logic [31:0] r0,
                         input logic [31:0] r1, input int sw, input int hold);
    exp_t        e;
    int          cyc;
    bit          seen;
    logic [15:0] v;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    predict(n, r0, r1, sw);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_bound = n;
    rng           = r0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_bound = 16'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      rng = (cyc >= sw) ? r1 : r0;
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    e = sb.pop_front();
    check("resp_seen", seen, 1);
    check("latency", cyc, e.lat);
    check("resp_value", bus.resp_value, e.val);
    check("reject_cnt", reject_cnt, e.rej);
    check("req_ready_busy", bus.req_ready, 0);
    v = bus.resp_value;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      rng           = $urandom;
      bus.req_bound = 16'($urandom);
      @(negedge clk);
      check("hold_valid", bus.resp_valid, 1);
      check("hold_value", bus.resp_value, v);
      check("hold_req_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("take_valid", bus.resp_valid, 1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after", bus.req_ready, 1);
    check("resp_valid_after", bus.resp_valid, 0);
  endtask

  initial begin
    logic [15:0] nlist [8];
    nlist = '{16'd0, 16'd1, 16'd3, 16'd6, 16'd7, 16'd1000, 16'd65535, 16'd6};
    bus.req_valid  = 1'b0;
    bus.req_bound  = 16'd0;
    bus.resp_ready = 1'b0;
    rng            = 32'd0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_value", bus.resp_value, 0);
    check("rst_reject_cnt", reject_cnt, 0);

    // N=6 uncached: first draw rejects, second accepts with 3
    run_req(16'd6, 32'h0000_0000, 32'h8000_0001, 34, 0);
    // N=6 cache hit
    run_req(16'd6, 32'h8000_0001, 32'h8000_0001, 0, 0);
    // N=65535, all-ones word
    run_req(16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    // N=0 full range
    run_req(16'd0, 32'h1234_ABCD, 32'h1234_ABCD, 0, 0);
    // N=1 uncached then cached
    run_req(16'd1, $urandom, $urandom, 0, 0);
    run_req(16'd1, $urandom, $urandom, 0, 0);
    // backpressure for 10 cycles
    run_req(16'd6, 32'h8000_0001, 32'h8000_0001, 0, 10);
    // different bound so the next N=6 goes through THRESH
    run_req(16'd1000, $urandom, $urandom, 0, 0);

    // reset in the middle of THRESH
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_bound = 16'd6;
    rng           = 32'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_reject_cnt", reject_cnt, 0);
    m_cv  = 1'b0;
    m_rej = 16'd0;
    run_req(16'd6, 32'h0000_0000, 32'h8000_0001, 34, 0);

    // a few random bounds, words and backpressure amounts
    for (int i = 0; i < 8; i++)
      run_req(nlist[$urandom_range(0, 7)], $urandom, $urandom,
              $urandom_range(0, 40), $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rng_range.md
# rng_range

Converts the free-running 32-bit PRNG word stream into unbiased integers in `[0, N)` on request. It is the consumer end of the PRNG output. Game and test logic issue a bound over a valid/ready request channel. The block draws PRNG words, multiplies each by `N`, rejects biased draws by comparing against a threshold computed once per bound (Lemire method), and returns the result over a valid/ready response channel.

## Interface
Parameters:
- `RNG_W`, 32: width of the PRNG word.
- `BOUND_W`, 16: width of the bound and the result.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `rng` in RNG_W: PRNG output; a new word every cycle, always valid.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_bound` in BOUND_W: the bound `N`. `0` means the full 2^16 range.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer takes the result.
- `resp_value` out BOUND_W: result in `[0, N)`.
- `reject_cnt` out 16: saturating count of rejected draws since reset.

## Operation
- States: `IDLE`, `THRESH`, `DRAW`, `DONE`.
- `IDLE`
  - `req_ready=1`.
  - On `req_valid`, latch `N`.
  - `N==0` or (cache valid and `N==cached_N`): go to `DRAW`.
  - Otherwise: go to `THRESH`.
- `THRESH`
  - Computes `thr = (2^32 - N) mod N` by restoring division, one quotient bit per cycle, 32 cycles.
  - The dividend is `(~{16'b0,N}) + 1` as 32 bits.
  - On completion, store `thr` and `cached_N`, set cache valid, go to `DRAW`.
- `DRAW`
  - Each cycle form `m = rng * N`, 48-bit unsigned.
  - `N==0`: accept with value `rng[15:0]`.
  - `N!=0`, `m[31:0] >= thr`: accept with value `m[47:32]`.
  - Otherwise reject: increment `reject_cnt`, saturating at 0xFFFF, and stay in `DRAW` to use the next `rng` word.
  - On accept, register `resp_value` and go to `DONE`.
- `DONE`
  - `resp_valid=1`; `resp_value` is held stable.
  - On `resp_ready`, go to `IDLE`.
- `N==1`: `thr=0`, so every draw accepts with value 0.
- The cache holds one bound only. A different `N` overwrites it.
- `req_bound` is ignored outside the accept cycle.
- `resp_valid` never deasserts without `resp_ready`.

## Timing
- Reset values:
  - state `IDLE`
  - `req_ready=1`
  - `resp_valid=0`
  - `resp_value=0`
  - `reject_cnt=0`
  - cache invalid, `thr=0`
- Reset takes priority in every state and aborts any division or draw in progress. Requests are accepted from the first cycle after reset deasserts.
- Request accepted at cycle 0:
  - Cached or `N==0`: `DRAW` samples `rng` at cycle 1; `resp_valid` at cycle 2 if there is no rejection.
  - Uncached: `THRESH` occupies cycles 1–32, `DRAW` is cycle 33, `resp_valid` at cycle 34.
- Each rejection adds exactly 1 cycle.
- Response taken at cycle k (`resp_valid && resp_ready`): `req_ready=1` at cycle k+1. One request is in flight at a time; `req_ready` and `resp_valid` are never both high.
- The multiplier is a single-cycle combinational 32×16. The compare and the result register sit on the same edge.

## Structure
- Package `rng_pkg` holds:
  - `RNG_W`, `BOUND_W`
  - the state enum `rr_state_t` (`IDLE`, `THRESH`, `DRAW`, `DONE`)
  - the threshold type `thr_t` (logic `[BOUND_W-1:0]`)
- Sub-module `rem_iter` is an iterative restoring remainder unit.
  - Ports: `clk`, `reset`, `start`, `dividend[31:0]`, `divisor[15:0]`, `busy`, `done`, `rem[15:0]`.
  - Takes 32 cycles per operation.
  - `done` pulses for 1 cycle.
- `rng_range` instantiates one `rem_iter` and contains the FSM, the multiplier, the cache and the counter.

## Test plan
- **`N=6` uncached, with rejections.**
  - Stimulus: bench drives `rng=0x00000000` then `0x80000001`.
  - Required: `thr=4`; the first draw rejects (`m[31:0]=0`) and the second accepts.
  - Required: `resp_value=3`, `resp_valid` at cycle 35, `reject_cnt=1`.
- **Repeat `N=6` (cache hit).**
  - Stimulus: `rng=0x80000001`.
  - Required: `resp_value=3`, `resp_valid` at cycle 2 with no `THRESH` visit.
- **`N=65535`.**
  - Stimulus: `rng=0xFFFFFFFF`.
  - Required: `thr=1`, `m=0xFFFEFFFF0001`, accept, `resp_value=0xFFFE`.
- **`N=0` and `N=1`.**
  - `N=0`, `rng=0x1234ABCD`: `resp_value=0xABCD` at cycle 2.
  - `N=1`, any `rng`: `resp_value=0` with no rejections.
- **Backpressure.**
  - Stimulus: hold `resp_ready=0` for 10 cycles.
  - Required: `resp_valid` and `resp_value` stay stable and `req_ready=0`.
  - After one cycle of `resp_ready=1`: `req_ready=1` on the next cycle.
- **Reset mid-`THRESH`.**
  - Stimulus: pulse `reset` at cycle 10 of a `N=6` request.
  - Required: the block returns to `IDLE` with `req_ready=1` and `reject_cnt=0`.
  - Required: a following `N=6` request takes the full 34-cycle path, i.e. the cache was cleared.
